stream_demux1_4: RTL

//  Registered 1-to-4 stream demultiplexer with valid/ready handshake.

---
 rtl/stream_demux1_4.sv | 72 +++++++
 1 files changed

// File: rtl/stream_demux1_4.sv
// stream_demux1_4: registered 1-to-4 valid/ready demux with 2-entry skid buffer
module stream_demux1_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [1:0]       i_in_sel,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [3:0]       o_out_valid,
  input  logic [3:0]       i_out_ready
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_hd_data, r_sk_data;
  logic [1:0]       r_hd_sel, r_sk_sel;
  logic             r_in_ready;
  logic             w_accept, w_drain, w_ld_hd, w_ld_sk, w_hd_sk;
  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_hd_data;
  assign o_out_valid = (r_state != EMPTY) ? (4'b1 << r_hd_sel) : 4'b0;
  assign w_accept    = i_in_valid & r_in_ready;
  assign w_drain     = |(o_out_valid & i_out_ready);
  always_comb begin
    w_nxt   = r_state;
    w_ld_hd = 1'b0;
    w_ld_sk = 1'b0;
    w_hd_sk = 1'b0;
    case (r_state)
      EMPTY: begin
        w_ld_hd = w_accept;
        w_nxt   = w_accept ? ONE : EMPTY;
      end
      ONE: begin
        w_ld_hd = w_accept & w_drain;
        w_ld_sk = w_accept & ~w_drain;
        w_nxt   = (w_accept & ~w_drain) ? TWO : (~w_accept & w_drain) ? EMPTY : ONE;
      end
      TWO: begin
        w_hd_sk = w_drain;
        w_nxt   = w_drain ? ONE : TWO;
      end
      default: w_nxt = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
      r_hd_data  <= '0;
      r_hd_sel   <= '0;
      r_sk_data  <= '0;
      r_sk_sel   <= '0;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= (w_nxt != TWO);
      if (w_ld_hd) begin
        r_hd_data <= i_in_data;
        r_hd_sel  <= i_in_sel;
      end else if (w_hd_sk) begin
        r_hd_data <= r_sk_data;
        r_hd_sel  <= r_sk_sel;
      end
      if (w_ld_sk) begin
        r_sk_data <= i_in_data;
        r_sk_sel  <= i_in_sel;
      end
    end
  end
endmodule
